// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: op codes, FSM state
// type and the shift-class classifier. Honours USR_ROTATE_EN: when undefined,
// ROR/ROL are not shift-class, so a start with those ops never begins a burst.
package usr_pkg;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_LOAD = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } usr_state_e;

    // Ops that a burst may repeat; load/hold/reserved never start a burst.
    function automatic logic is_shift_op(input logic [2:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_SHR, OP_SHL, OP_ASR: r = 1'b1;
`ifdef USR_ROTATE_EN
            OP_ROR, OP_ROL:         r = 1'b1;
`endif
            default:                r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/usr_step.sv
// One step of the shift register: next contents from the current contents,
// op, serial inputs and load data. Shared by the single-step and burst paths.
// Honours USR_ROTATE_EN: when undefined, ROR/ROL act as hold.
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       op,
    input  logic             sl,
    input  logic             sr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_nxt
);

    // Select the next register value for the requested op.
    always_comb begin
        q_nxt = q;
        case (op)
            OP_SHR:  q_nxt = {sr, q[WIDTH-1:1]};
            OP_SHL:  q_nxt = {q[WIDTH-2:0], sl};
            OP_LOAD: q_nxt = d;
`ifdef USR_ROTATE_EN
            OP_ROR:  q_nxt = {q[0], q[WIDTH-1:1]};
            OP_ROL:  q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
`endif
            OP_ASR:  q_nxt = {q[WIDTH-1], q[WIDTH-1:1]};
            default: q_nxt = q;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg_param.sv
// Parametrised universal shift register with a burst engine that repeats a
// shift-class op amt times (busy/done handshake). Optional rotate ops are
// enabled by defining USR_ROTATE_EN.
module univ_shift_reg_param
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] d,
    input  logic             sl,
    input  logic             sr,
    input  logic             start,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] q,
    output logic             so_l,
    output logic             so_r,
    output logic             busy,
    output logic             done
);

    usr_state_e       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_lat_q, op_lat_d;
    logic             done_q, done_d;

    logic [2:0]       step_op;
    logic [WIDTH-1:0] step_q;
    logic [AMT_W-1:0] amt_c;

    // Bursts use the op latched at start; otherwise the live op drives the step.
    always_comb begin
        step_op = (state_q == ST_RUN) ? op_lat_q : op;
        amt_c   = (amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amt;
    end

    usr_step #(.WIDTH(WIDTH)) u_step (
        .q     (q_q),
        .op    (step_op),
        .sl    (sl),
        .sr    (sr),
        .d     (d),
        .q_nxt (step_q)
    );

    // Next-state: running burst beats start, start beats single-step enable.
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        cnt_d    = cnt_q;
        op_lat_d = op_lat_q;
        done_d   = 1'b0;
        if (state_q == ST_RUN) begin
            q_d   = step_q;
            cnt_d = cnt_q - AMT_W'(1);
            if (cnt_q == AMT_W'(1)) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end else if (start && is_shift_op(op)) begin
            op_lat_d = op;
            if (amt_c == '0) begin
                // Zero-length burst: leave q alone, just acknowledge.
                done_d = 1'b1;
            end else begin
                q_d   = step_q;
                cnt_d = amt_c - AMT_W'(1);
                if (amt_c == AMT_W'(1)) begin
                    done_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
        end else if (en) begin
            q_d = step_q;
        end
    end

    // State registers; clr aborts any burst without a done pulse.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= ST_IDLE;
            q_q      <= '0;
            cnt_q    <= '0;
            op_lat_q <= OP_HOLD;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            cnt_q    <= cnt_d;
            op_lat_q <= op_lat_d;
            done_q   <= done_d;
        end
    end

    assign q    = q_q;
    assign so_l = q_q[WIDTH-1];
    assign so_r = q_q[0];
    assign busy = (state_q == ST_RUN);
    assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg_param.sv
// Self-checking bench for univ_shift_reg_param (WIDTH=8): directed scenarios
// plus randomized traffic against a cycle-level behavioural model.
module tb_univ_shift_reg_param;

    localparam int W  = 8;
    localparam int AW = $clog2(W + 1);
    localparam int MASK = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          clr, en, start, sl, sr;
    logic [2:0]    op;
    logic [W-1:0]  d;
    logic [AW-1:0] amt;
    logic [W-1:0]  q;
    logic          so_l, so_r, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int m_q   = 0;
    int m_rem = 0;
    int m_op  = 0;
    bit m_done = 1'b0;

    univ_shift_reg_param #(.WIDTH(W)) dut (
        .clk   (clk),
        .clr   (clr),
        .en    (en),
        .op    (op),
        .d     (d),
        .sl    (sl),
        .sr    (sr),
        .start (start),
        .amt   (amt),
        .q     (q),
        .so_l  (so_l),
        .so_r  (so_r),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

`ifdef USR_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    function automatic bit m_is_shift(input int o);
        return (o == 1) || (o == 2) || (o == 6) || (ROT && (o == 4 || o == 5));
    endfunction

    function automatic int m_apply(input int o, input int qv, input bit sli, input bit sri, input int dv);
        int msb;
        msb = 1 << (W - 1);
        case (o)
            1: return (qv >> 1) | (sri ? msb : 0);
            2: return ((qv * 2) + sli) & MASK;
            3: return dv & MASK;
            4: return ROT ? ((qv >> 1) | ((qv % 2) * msb)) : qv;
            5: return ROT ? (((qv * 2) & MASK) | (qv / msb)) : qv;
            6: return (qv >> 1) | (qv & msb);
            default: return qv;
        endcase
    endfunction

    // Advance model and DUT one clock, then compare all outputs.
    task automatic tick();
        int nq, nrem, nop, n;
        bit ndone;
        nq = m_q; nrem = m_rem; nop = m_op; ndone = 1'b0;
        if (clr) begin
            nq = 0; nrem = 0; nop = 0;
        end else if (m_rem > 0) begin
            nq = m_apply(m_op, m_q, sl, sr, d);
            nrem = m_rem - 1;
            ndone = (nrem == 0);
        end else if (start && m_is_shift(op)) begin
            n = (amt > W) ? W : amt;
            nop = op;
            if (n == 0) ndone = 1'b1;
            else begin
                nq = m_apply(op, m_q, sl, sr, d);
                nrem = n - 1;
                ndone = (n == 1);
            end
        end else if (en) begin
            nq = m_apply(op, m_q, sl, sr, d);
        end
        @(posedge clk);
        #1;
        m_q = nq; m_rem = nrem; m_op = nop; m_done = ndone;
        chk("model_q", 32'(q), 32'(m_q));
        chk("model_busy", 32'(busy), 32'(m_rem > 0));
        chk("model_done", 32'(done), 32'(m_done));
        chk("model_so", {30'd0, so_l, so_r}, {30'd0, 1'(m_q >> (W - 1)), 1'(m_q % 2)});
    endtask

    task automatic quiet();
        clr = 1'b0; en = 1'b0; start = 1'b0;
    endtask

    task automatic load(input logic [W-1:0] v);
        quiet();
        en = 1'b1; op = 3'b011; d = v;
        tick();
        en = 1'b0;
    endtask

    initial begin
        clr = 1'b1; en = 1'b0; start = 1'b0; sl = 1'b0; sr = 1'b0;
        op = 3'b000; d = '0; amt = '0;

        // Reset
        tick(); tick();
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        clr = 1'b0;

        // Parallel load
        load(8'hA5);
        chk("load_q", 32'(q), 32'hA5);
        chk("load_so", {30'd0, so_l, so_r}, 32'h3);

        // SHR burst of 3 with sr=1
        start = 1'b1; op = 3'b001; amt = AW'(3); sr = 1'b1;
        tick();
        start = 1'b0;
        chk("shr_busy1", 32'(busy), 32'h1);
        tick();
        chk("shr_busy2", 32'(busy), 32'h1);
        tick();
        chk("shr_q", 32'(q), 32'hF4);
        chk("shr_done", 32'(done), 32'h1);
        chk("shr_busy_end", 32'(busy), 32'h0);
        tick();
        chk("shr_done_clr", 32'(done), 32'h0);

        // ROL burst of 8
        load(8'h81);
        start = 1'b1; op = 3'b101; amt = AW'(8);
        tick();
        start = 1'b0;
        if (ROT) begin
            for (int i = 0; i < 7; i++) tick();
            chk("rol_q", 32'(q), 32'h81);
            chk("rol_done", 32'(done), 32'h1);
        end else begin
            chk("rol_off_busy", 32'(busy), 32'h0);
            chk("rol_off_done", 32'(done), 32'h0);
            tick();
            chk("rol_off_q", 32'(q), 32'h81);
            chk("rol_off_done2", 32'(done), 32'h0);
        end

        // ASR single steps
        load(8'h90);
        en = 1'b1; op = 3'b110; sr = 1'b0;
        tick();
        chk("asr_q1", 32'(q), 32'hC8);
        tick();
        chk("asr_q2", 32'(q), 32'hE4);
        en = 1'b0;

        // SHL burst aborted by clr on third step edge
        load(8'hFF);
        start = 1'b1; op = 3'b010; amt = AW'(5); sl = 1'b0;
        tick();
        start = 1'b0;
        tick();
        chk("abort_mid_q", 32'(q), 32'hFC);
        clr = 1'b1;
        tick();
        chk("abort_q", 32'(q), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        clr = 1'b0;
        tick();
        chk("abort_done_next", 32'(done), 32'h0);

        // amt=0, then back-to-back burst from the done cycle
        load(8'h3C);
        start = 1'b1; op = 3'b001; amt = '0;
        tick();
        chk("amt0_q", 32'(q), 32'h3C);
        chk("amt0_done", 32'(done), 32'h1);
        chk("amt0_busy", 32'(busy), 32'h0);
        op = 3'b010; amt = AW'(2); sl = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'h1);
        chk("b2b_done_low", 32'(done), 32'h0);
        tick();
        chk("b2b_q", 32'(q), 32'hF3);
        chk("b2b_done", 32'(done), 32'h1);

        // Clamp: amt above WIDTH runs WIDTH steps
        load(8'h01);
        start = 1'b1; op = 3'b010; amt = AW'(15); sl = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("clamp_done", 32'(done), 32'h1);
        chk("clamp_q", 32'(q), 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            clr   = ($urandom_range(0, 63) == 0);
            en    = $urandom_range(0, 1);
            start = ($urandom_range(0, 5) == 0);
            op    = 3'($urandom_range(0, 7));
            d     = W'($urandom);
            sl    = $urandom_range(0, 1);
            sr    = $urandom_range(0, 1);
            amt   = AW'($urandom_range(0, 15));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
